// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter:
//               FSM state encoding, grant-mode constants and the grant
//               index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Grant policy selectors
    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    // Width of a channel index; a single channel still needs one bit
    function automatic int grant_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the per-channel cache-controller handshake and the
//               single main-memory handshake seen by the arbiter.
//               master = arbiter side, slave = controllers + memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // Channel side: channel i occupies slice [i*W +: W] of each flat bus
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*DATA_W-1:0] ch_writedata;
    logic [NUM_CH*DATA_W-1:0] ch_readdata;
    logic [NUM_CH-1:0]        ch_busywait;

    // Memory side
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_address;
    logic [DATA_W-1:0]        mem_writedata;
    logic [DATA_W-1:0]        mem_readdata;
    logic                     mem_busywait;

    modport master (
        input  ch_read, ch_write, ch_address, ch_writedata,
        output ch_readdata, ch_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport slave (
        output ch_read, ch_write, ch_address, ch_writedata,
        input  ch_readdata, ch_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_picker.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_picker
// Description : Combinational winner select. Round-robin searches upward
//               from last+1 with wrap-around; fixed mode picks the lowest
//               requesting index and ignores the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int GRANT_W = 1
) (
    input  wire logic [NUM_CH-1:0]  i_req,
    input  wire logic [GRANT_W-1:0] i_last,
    input  wire logic               i_mode,
    output logic      [GRANT_W-1:0] o_grant,
    output logic                    o_valid
);

    int w_best;
    int w_dist;

    // Rank each requester by its distance from the search start; smallest wins
    always_comb begin
        o_grant = '0;
        o_valid = |i_req;
        w_best  = NUM_CH;
        w_dist  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_mode == PRIO_FIXED) begin
                w_dist = i;
            end else begin
                // last+1 gets distance 0, last itself gets NUM_CH-1
                w_dist = (i + NUM_CH - 1 - int'(i_last)) % NUM_CH;
            end
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_grant = GRANT_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : N-channel arbiter sharing one block-granular main memory
//               between cache controllers over the READ/WRITE/BUSYWAIT
//               handshake. One memory transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.master  bus
);

    localparam int   GRANT_W = grant_width(NUM_CH);
    localparam logic c_mode  = (PRIO_MODE != 0) ? PRIO_FIXED : PRIO_RR;

    arb_state_t          r_state;
    logic [GRANT_W-1:0]  r_grant;
    logic [GRANT_W-1:0]  r_last;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_writedata;
    logic [DATA_W-1:0]   r_readdata [NUM_CH];

    logic [NUM_CH-1:0]   w_req;
    logic [GRANT_W-1:0]  w_pick;
    logic                w_pick_valid;
    logic                w_sel_read;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_address;
    logic [DATA_W-1:0]   w_sel_writedata;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_req[i] = bus.ch_read[i] | bus.ch_write[i];
            // Only the granted channel is released, and only for the DONE cycle
            assign bus.ch_busywait[i] = w_req[i] &
                ~((r_state == ST_DONE) && (r_grant == GRANT_W'(i)));
            assign bus.ch_readdata[i*DATA_W +: DATA_W] = r_readdata[i];
        end
    endgenerate

    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_writedata = r_mem_writedata;

    mem_arb_picker #(
        .NUM_CH  (NUM_CH),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .i_req   (w_req),
        .i_last  (r_last),
        .i_mode  (c_mode),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // Route the picked channel's request fields toward the memory registers
    always_comb begin
        w_sel_read      = 1'b0;
        w_sel_write     = 1'b0;
        w_sel_address   = '0;
        w_sel_writedata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (GRANT_W'(i) == w_pick) begin
                w_sel_read      = bus.ch_read[i];
                w_sel_write     = bus.ch_write[i];
                w_sel_address   = bus.ch_address[i*ADDR_W +: ADDR_W];
                w_sel_writedata = bus.ch_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM with registered memory controls and read-return registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_grant         <= '0;
            r_last          <= GRANT_W'(NUM_CH - 1);
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_readdata[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant         <= w_pick;
                        // READ together with WRITE is treated as a write
                        r_mem_read      <= w_sel_read & ~w_sel_write;
                        r_mem_write     <= w_sel_write;
                        r_mem_address   <= w_sel_address;
                        r_mem_writedata <= w_sel_writedata;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Enables stay up one cycle so memory can raise its busywait
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The access always runs to completion, even if the requester left
                    if (!bus.mem_busywait) begin
                        if (r_mem_read) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (GRANT_W'(i) == r_grant) begin
                                    r_readdata[i] <= bus.mem_readdata;
                                end
                            end
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_grant;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. One round-robin and
//               one fixed-priority instance, each behind a 5-cycle
//               busywait memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        int          d;
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    int          n_chk;
    int          n_fail;
    exp_t        sb[$];
    exp_t        e;

    bit          c_rd   [2][2];
    bit          c_wr   [2][2];
    logic [5:0]  c_addr [2][2];
    logic [31:0] c_wd   [2][2];
    logic [1:0]  bw     [2];
    logic [31:0] rdq    [2][2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic        m_busy [2];
    logic        m_hold [2];
    logic [5:0]  m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rdata[2];
    int          m_cnt  [2];
    logic [31:0] mem    [2][64];

    mem_port_arbiter_if #(.NUM_CH(2), .ADDR_W(6), .DATA_W(32)) bus_rr ();
    mem_port_arbiter_if #(.NUM_CH(2), .ADDR_W(6), .DATA_W(32)) bus_fx ();

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(6), .DATA_W(32), .PRIO_MODE(0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(6), .DATA_W(32), .PRIO_MODE(1)) dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (bus_fx)
    );

    assign bus_rr.ch_read      = {c_rd[0][1], c_rd[0][0]};
    assign bus_rr.ch_write     = {c_wr[0][1], c_wr[0][0]};
    assign bus_rr.ch_address   = {c_addr[0][1], c_addr[0][0]};
    assign bus_rr.ch_writedata = {c_wd[0][1], c_wd[0][0]};
    assign bus_fx.ch_read      = {c_rd[1][1], c_rd[1][0]};
    assign bus_fx.ch_write     = {c_wr[1][1], c_wr[1][0]};
    assign bus_fx.ch_address   = {c_addr[1][1], c_addr[1][0]};
    assign bus_fx.ch_writedata = {c_wd[1][1], c_wd[1][0]};

    assign bw[0]     = bus_rr.ch_busywait;
    assign bw[1]     = bus_fx.ch_busywait;
    assign rdq[0][0] = bus_rr.ch_readdata[31:0];
    assign rdq[0][1] = bus_rr.ch_readdata[63:32];
    assign rdq[1][0] = bus_fx.ch_readdata[31:0];
    assign rdq[1][1] = bus_fx.ch_readdata[63:32];

    assign m_rd[0]   = bus_rr.mem_read;
    assign m_wr[0]   = bus_rr.mem_write;
    assign m_addr[0] = bus_rr.mem_address;
    assign m_wd[0]   = bus_rr.mem_writedata;
    assign m_rd[1]   = bus_fx.mem_read;
    assign m_wr[1]   = bus_fx.mem_write;
    assign m_addr[1] = bus_fx.mem_address;
    assign m_wd[1]   = bus_fx.mem_writedata;

    assign bus_rr.mem_busywait = m_busy[0];
    assign bus_rr.mem_readdata = m_rdata[0];
    assign bus_fx.mem_busywait = m_busy[1];
    assign bus_fx.mem_readdata = m_rdata[1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: busywait high 5 cycles after an enable, access on the last
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_busy[m]  <= 1'b0;
                m_hold[m]  <= 1'b0;
                m_cnt[m]   <= 0;
                m_rdata[m] <= '0;
                for (int a = 0; a < 64; a++) begin
                    mem[m][a] <= 32'hA000_0000 | 32'(a);
                end
                mem[m][5] <= 32'hDEAD_BEEF;
            end else if (m_hold[m]) begin
                m_hold[m] <= 1'b0;
            end else if (m_busy[m]) begin
                if (m_cnt[m] == 1) begin
                    m_busy[m] <= 1'b0;
                    m_hold[m] <= 1'b1;
                    if (m_wr[m]) begin
                        mem[m][m_addr[m]] <= m_wd[m];
                    end else begin
                        m_rdata[m] <= mem[m][m_addr[m]];
                    end
                end else begin
                    m_cnt[m] <= m_cnt[m] - 1;
                end
            end else if (m_rd[m] || m_wr[m]) begin
                m_busy[m] <= 1'b1;
                m_cnt[m]  <= 5;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_done(input int d, input int ch, input logic [31:0] data);
        sb.push_back('{d: d, ch: ch, data: data});
    endtask

    // Monitor: every channel release is matched against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if ((c_rd[d][ch] || c_wr[d][ch]) && !bw[d][ch]) begin
                        if (sb.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_release: dut %0d ch %0d, no entry expected", d, ch);
                        end else begin
                            e = sb.pop_front();
                            chk("release_dut_ch", 32'(d * 2 + ch), 32'(e.d * 2 + e.ch));
                            chk("release_readdata", rdq[d][ch], e.data);
                        end
                    end
                end
            end
        end
    end

    // Controller model: request, wait for release, drop request after the monitor saw it
    task automatic xact(input int d, input int ch, input bit rd, input bit wr,
                        input logic [5:0] a, input logic [31:0] wd);
        c_rd[d][ch]   = rd;
        c_wr[d][ch]   = wr;
        c_addr[d][ch] = a;
        c_wd[d][ch]   = wd;
        for (int n = 0; n < 120; n++) begin
            @(posedge clk);
            #1;
            if (!bw[d][ch]) begin
                @(negedge clk);
                #1;
                c_rd[d][ch] = 1'b0;
                c_wr[d][ch] = 1'b0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL xact_timeout: dut %0d ch %0d got no release, expected one within 120 cycles", d, ch);
        c_rd[d][ch] = 1'b0;
        c_wr[d][ch] = 1'b0;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  addr_ok;
        bit  done;
        n_chk  = 0;
        n_fail = 0;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                c_rd[d][ch]   = 1'b0;
                c_wr[d][ch]   = 1'b0;
                c_addr[d][ch] = '0;
                c_wd[d][ch]   = '0;
            end
        end

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mem_read", 32'(m_rd[0]), 32'd0);
        chk("rst_mem_write", 32'(m_wr[0]), 32'd0);
        chk("rst_mem_address", 32'(m_addr[0]), 32'd0);
        chk("rst_mem_writedata", m_wd[0], 32'd0);
        chk("rst_readdata0", rdq[0][0], 32'd0);
        chk("rst_readdata1", rdq[0][1], 32'd0);
        chk("rst_busywait", 32'(bw[0]), 32'd0);
        chk("rst_state", 32'(dut_rr.r_state), 32'(ST_IDLE));
        chk("rst_last", 32'(dut_rr.r_last), 32'd1);

        // Single uncontended read: ch0 at 0x05
        expect_done(0, 0, 32'hDEAD_BEEF);
        c_rd[0][0]   = 1'b1;
        c_addr[0][0] = 6'h05;
        lat     = 0;
        addr_ok = 1'b1;
        done    = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (dut_rr.r_state != ST_IDLE && m_addr[0] != 6'h05) addr_ok = 1'b0;
            if (!bw[0][0]) done = 1'b1;
        end
        chk("single_latency", 32'(lat), 32'd8);
        chk("single_addr_held", 32'(addr_ok), 32'd1);
        @(posedge clk);
        #1;
        chk("single_busywait_one_cycle", 32'(bw[0][0]), 32'd1);
        c_rd[0][0] = 1'b0;

        // Reset during WAIT aborts ch1 read at 0x06
        c_rd[0][1]   = 1'b1;
        c_addr[0][1] = 6'h06;
        repeat (4) @(posedge clk);
        #1;
        chk("midwait_state_before", 32'(dut_rr.r_state), 32'(ST_WAIT));
        rst        = 1'b1;
        c_rd[0][1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midwait_mem_read", 32'(m_rd[0]), 32'd0);
        chk("midwait_state", 32'(dut_rr.r_state), 32'(ST_IDLE));
        chk("midwait_readdata0", rdq[0][0], 32'd0);
        chk("midwait_readdata1", rdq[0][1], 32'd0);
        chk("midwait_last", 32'(dut_rr.r_last), 32'd1);

        // Contention: ch0 read 0x01 and ch1 write 0x02 in the same cycle
        expect_done(0, 0, 32'hA000_0001);
        expect_done(0, 1, 32'h0000_0000);
        fork
            xact(0, 0, 1'b1, 1'b0, 6'h01, 32'h0);
            xact(0, 1, 1'b0, 1'b1, 6'h02, 32'h1234_5678);
        join
        chk("contend_mem_write", mem[0][2], 32'h1234_5678);

        // Continuous requests, round-robin alternates 0,1,0,1
        expect_done(0, 0, 32'hA000_0010);
        expect_done(0, 1, 32'hA000_0020);
        expect_done(0, 0, 32'hA000_0011);
        expect_done(0, 1, 32'hA000_0021);
        fork
            begin
                xact(0, 0, 1'b1, 1'b0, 6'h10, 32'h0);
                xact(0, 0, 1'b1, 1'b0, 6'h11, 32'h0);
            end
            begin
                xact(0, 1, 1'b1, 1'b0, 6'h20, 32'h0);
                xact(0, 1, 1'b1, 1'b0, 6'h21, 32'h0);
            end
        join

        // READ and WRITE together at 0x3F acts as a write
        expect_done(0, 1, 32'hA000_0021);
        xact(0, 1, 1'b1, 1'b1, 6'h3F, 32'h5A5A_3F3F);
        chk("rw_mem_write", mem[0][63], 32'h5A5A_3F3F);

        // ch0 write dropped during WAIT still completes; ch1 read served next
        expect_done(0, 1, 32'hA000_000A);
        fork
            begin
                c_wr[0][0]   = 1'b1;
                c_addr[0][0] = 6'h09;
                c_wd[0][0]   = 32'hCAFE_0009;
                repeat (4) @(posedge clk);
                #1;
                chk("drop_state_wait", 32'(dut_rr.r_state), 32'(ST_WAIT));
                c_wr[0][0] = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                xact(0, 1, 1'b1, 1'b0, 6'h0A, 32'h0);
            end
        join
        chk("drop_mem_write", mem[0][9], 32'hCAFE_0009);
        chk("drop_readdata0_held", rdq[0][0], 32'hA000_0011);

        // Fixed priority: ch0 re-requests four times, ch1 waits until it stops
        for (int i = 0; i < 4; i++) expect_done(1, 0, 32'hA000_0030 + 32'(i));
        expect_done(1, 1, 32'hA000_0034);
        fork
            begin
                for (int i = 0; i < 4; i++) xact(1, 0, 1'b1, 1'b0, 6'(48 + i), 32'h0);
            end
            xact(1, 1, 1'b1, 1'b0, 6'h34, 32'h0);
        join

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
